// File: rtl/npc_pkg.sv
// Shared integer-pipeline parameters and the writeback request record used by EXU, LSU and
// the writeback unit.
package npc_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned REG_NUM = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits tracking issued-but-not-yet-written destinations, with two
// combinational query ports for decode hazard checks.
module wb_scoreboard
    import npc_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_iss_valid,
    input  logic [REG_AW-1:0] i_iss_rd,
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy
);

    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_busy_d;

    always_comb begin
        w_busy_d = r_busy;
        if (i_flush) begin
            w_busy_d = '0;
        end else begin
            if (i_wr_en) begin
                w_busy_d[i_wr_addr] = 1'b0;
            end
            // Applied after the clear so a new producer for the same register wins.
            if (i_iss_valid) begin
                w_busy_d[i_iss_rd] = 1'b1;
            end
            w_busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];

endmodule

// File: rtl/reg_writeback_unit.sv
// Register file write-side owner: LSU-over-EXU arbitration, one registered write stage and the
// RAW hazard scoreboard.
module reg_writeback_unit
    import npc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              flush,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic [REG_AW-1:0] exu_rd,
    input  logic [XLEN-1:0]   exu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    logic              w_lsu_acc;
    logic              w_exu_acc;
    logic              w_wr;
    wb_req_t           w_sel;

    logic              r_wen;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;

    always_comb begin
        lsu_ready = ~flush;
        exu_ready = ~flush & ~lsu_valid;
        w_lsu_acc = lsu_valid & lsu_ready;
        w_exu_acc = exu_valid & exu_ready;
        w_sel     = w_lsu_acc ? '{rd: lsu_rd, data: lsu_data} : '{rd: exu_rd, data: exu_data};
        // Writes to x0 are accepted and dropped here.
        w_wr      = (w_lsu_acc | w_exu_acc) & (w_sel.rd != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_wr;
            if (w_wr) begin
                r_waddr <= w_sel.rd;
                r_wdata <= w_sel.data;
            end
        end
    end

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

    wb_scoreboard u_scoreboard (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_flush     (flush),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .i_wr_en     (r_wen),
        .i_wr_addr   (r_waddr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed scenarios plus a randomized run against a behavioural model of the writeback unit.
module tb_reg_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    bit          m_busy [32];
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    bit          last_al;
    bit          last_ae;

    always #5 clock = ~clock;

    reg_writeback_unit dut (
        .clock     (clock),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

    // Advance one clock, evolving the model from the inputs present before the edge.
    task automatic tick();
        bit          nb [32];
        bit          nwen;
        logic [4:0]  na;
        logic [63:0] nd;
        bit          al;
        bit          ae;
        al   = lsu_valid && !flush;
        ae   = exu_valid && !flush && !lsu_valid;
        nb   = m_busy;
        na   = m_waddr;
        nd   = m_wdata;
        nwen = 1'b0;
        if (reset) begin
            foreach (nb[i]) nb[i] = 1'b0;
            na = '0;
            nd = '0;
        end else begin
            if (al && lsu_rd != 0) begin
                nwen = 1'b1; na = lsu_rd; nd = lsu_data;
            end else if (ae && exu_rd != 0) begin
                nwen = 1'b1; na = exu_rd; nd = exu_data;
            end
            if (flush) begin
                foreach (nb[i]) nb[i] = 1'b0;
            end else begin
                if (m_wen) nb[m_waddr] = 1'b0;
                if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
            end
        end
        last_al = al;
        last_ae = ae;
        @(posedge clock);
        #1;
        m_busy  = nb;
        m_wen   = nwen;
        m_waddr = na;
        m_wdata = nd;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd = 0; flush = 0;
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        n_total++;
        if (rf_wen !== 1'b0) $display("FAIL reset_wen got=%b exp=0", rf_wen); else n_pass++;
        n_total++;
        if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); else n_pass++;
        n_total++;
        if (rf_wdata !== 64'd0) $display("FAIL reset_wdata got=%h exp=0", rf_wdata); else n_pass++;
        n_total++;
        if ({rs1_busy, rs2_busy} !== 2'b00)
            $display("FAIL reset_busy got=%b%b exp=00", rs1_busy, rs2_busy);
        else n_pass++;
    endtask

    task automatic test_single_exu();
        iss_valid = 1; iss_rd = 5; rs1_addr = 5;
        tick();
        iss_valid = 0;
        #1;
        n_total++;
        if (rs1_busy !== 1'b1) $display("FAIL exu_busy_after_issue got=%b exp=1", rs1_busy);
        else n_pass++;
        exu_valid = 1; exu_rd = 5; exu_data = 64'hDEAD_BEEF;
        #1;
        n_total++;
        if (exu_ready !== 1'b1) $display("FAIL exu_ready got=%b exp=1", exu_ready); else n_pass++;
        tick();
        exu_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 64'hDEAD_BEEF})
            $display("FAIL exu_write got=%b/%0d/%h exp=1/5/deadbeef", rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        n_total++;
        if (rs1_busy !== 1'b1) $display("FAIL exu_busy_in_write got=%b exp=1", rs1_busy);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_wen, rs1_busy} !== 2'b00)
            $display("FAIL exu_after_write got=wen%b busy%b exp=00", rf_wen, rs1_busy);
        else n_pass++;
    endtask

    task automatic test_contention();
        lsu_valid = 1; lsu_rd = 3; lsu_data = 64'h3333_0000_1111_aaaa;
        exu_valid = 1; exu_rd = 4; exu_data = 64'h4444_5555_6666_7777;
        #1;
        n_total++;
        if ({lsu_ready, exu_ready} !== 2'b10)
            $display("FAIL cont_ready got=lsu%b exu%b exp=lsu1 exu0", lsu_ready, exu_ready);
        else n_pass++;
        tick();
        lsu_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 64'h3333_0000_1111_aaaa})
            $display("FAIL cont_lsu_write got=%b/%0d/%h", rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        n_total++;
        if (exu_ready !== 1'b1) $display("FAIL cont_exu_ready2 got=%b exp=1", exu_ready);
        else n_pass++;
        tick();
        exu_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 64'h4444_5555_6666_7777})
            $display("FAIL cont_exu_write got=%b/%0d/%h", rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        exu_valid = 1; exu_rd = 0; exu_data = 64'h1;
        iss_valid = 1; iss_rd = 0; rs1_addr = 0;
        #1;
        n_total++;
        if (exu_ready !== 1'b1) $display("FAIL x0_ready got=%b exp=1", exu_ready); else n_pass++;
        tick();
        exu_valid = 0; iss_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, rs1_busy} !== 2'b00)
            $display("FAIL x0_nowrite got=wen%b busy%b exp=00", rf_wen, rs1_busy);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_wen, rs1_busy} !== 2'b00)
            $display("FAIL x0_after got=wen%b busy%b exp=00", rf_wen, rs1_busy);
        else n_pass++;
    endtask

    task automatic test_collision();
        iss_valid = 1; iss_rd = 7; rs1_addr = 7;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 7; exu_data = 64'h77;
        tick();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 7;
        #1;
        n_total++;
        if ({rf_wen, rf_waddr} !== {1'b1, 5'd7})
            $display("FAIL coll_stage got=%b/%0d exp=1/7", rf_wen, rf_waddr);
        else n_pass++;
        tick();
        iss_valid = 0;
        #1;
        n_total++;
        if (rs1_busy !== 1'b1) $display("FAIL coll_busy got=%b exp=1", rs1_busy); else n_pass++;
        exu_valid = 1; exu_rd = 7; exu_data = 64'h78;
        tick();
        exu_valid = 0;
        tick();
        n_total++;
        if (rs1_busy !== 1'b0) $display("FAIL coll_release got=%b exp=0", rs1_busy); else n_pass++;
    endtask

    task automatic test_flush();
        iss_valid = 1; iss_rd = 2;
        tick();
        iss_rd = 9;
        tick();
        iss_valid = 0; rs1_addr = 2; rs2_addr = 9;
        #1;
        n_total++;
        if ({rs1_busy, rs2_busy} !== 2'b11)
            $display("FAIL flush_pre_busy got=%b%b exp=11", rs1_busy, rs2_busy);
        else n_pass++;
        flush = 1; exu_valid = 1; exu_rd = 2; exu_data = 64'h22;
        iss_valid = 1; iss_rd = 12;
        #1;
        n_total++;
        if ({exu_ready, lsu_ready} !== 2'b00)
            $display("FAIL flush_ready got=exu%b lsu%b exp=00", exu_ready, lsu_ready);
        else n_pass++;
        tick();
        flush = 0; exu_valid = 0; iss_valid = 0;
        #1;
        n_total++;
        if ({rs1_busy, rs2_busy, rf_wen} !== 3'b000)
            $display("FAIL flush_clear got=busy%b%b wen%b exp=000", rs1_busy, rs2_busy, rf_wen);
        else n_pass++;
        rs1_addr = 12;
        #1;
        n_total++;
        if (rs1_busy !== 1'b0) $display("FAIL flush_iss_ignored got=%b exp=0", rs1_busy);
        else n_pass++;
    endtask

    task automatic test_random();
        bit el;
        bit ee;
        bit eb1;
        bit eb2;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!(lsu_valid && !last_al)) begin
                lsu_valid = ($urandom_range(0, 3) == 0);
                lsu_rd    = 5'($urandom);
                lsu_data  = {$urandom, $urandom};
            end
            if (!(exu_valid && !last_ae)) begin
                exu_valid = ($urandom_range(0, 1) == 0);
                exu_rd    = 5'($urandom);
                exu_data  = {$urandom, $urandom};
            end
            iss_valid = ($urandom_range(0, 1) == 0);
            iss_rd    = 5'($urandom);
            flush     = ($urandom_range(0, 14) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            rs1_addr  = 5'($urandom);
            rs2_addr  = 5'($urandom);
            #1;
            el  = !flush;
            ee  = !flush && !lsu_valid;
            eb1 = (rs1_addr != 0) && m_busy[rs1_addr];
            eb2 = (rs2_addr != 0) && m_busy[rs2_addr];
            n_total++;
            if ({lsu_ready, exu_ready} !== {el, ee})
                $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, lsu_ready, exu_ready,
                         el, ee);
            else n_pass++;
            n_total++;
            if ({rf_wen, rf_waddr, rf_wdata} !== {m_wen, m_waddr, m_wdata})
                $display("FAIL rnd_rf cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, rf_wen,
                         rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
            else n_pass++;
            n_total++;
            if ({rs1_busy, rs2_busy} !== {eb1, eb2})
                $display("FAIL rnd_busy cyc=%0d rs1=%0d rs2=%0d got=%b%b exp=%b%b", cyc,
                         rs1_addr, rs2_addr, rs1_busy, rs2_busy, eb1, eb2);
            else n_pass++;
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_exu();
        test_contention();
        test_x0();
        test_collision();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
